// File: rtl/fault_vote_pkg.sv
// Shared types and helpers for the N-way redundant result voter.
package fault_vote_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCollect,
    StVote,
    StDone,
    StLock
  } state_e;

  // Width of a saturating counter that must reach maxf.
  function automatic int unsigned cnt_width(input int unsigned maxf);
    return $clog2(maxf + 1);
  endfunction

endpackage

// File: rtl/fault_vote_ctrl_bit_majority_n.sv
// Combinational bitwise majority over the captured channels plus the count of
// captured channels that agree exactly with that majority.
module bit_majority_n #(
  parameter int unsigned N = 3,
  parameter int unsigned W = 128
) (
  input  logic [N*W-1:0]           regs_i,
  input  logic [N-1:0]             cap_i,
  output logic [W-1:0]             maj_o,
  output logic [$clog2(N+1)-1:0]   agree_o
);

  localparam int unsigned CW = $clog2(N + 1);

  logic [CW-1:0] bit_cnt;

  // Threshold is over N, so uncaptured channels act as zero votes.
  always_comb begin
    maj_o   = '0;
    bit_cnt = '0;
    for (int b = 0; b < W; b++) begin
      bit_cnt = '0;
      for (int i = 0; i < N; i++) begin
        if (cap_i[i] && regs_i[i*W+b]) bit_cnt = bit_cnt + CW'(1);
      end
      maj_o[b] = (bit_cnt > CW'(N / 2));
    end
  end

  always_comb begin
    agree_o = '0;
    for (int i = 0; i < N; i++) begin
      if (cap_i[i] && (regs_i[i*W +: W] == maj_o)) agree_o = agree_o + CW'(1);
    end
  end

endmodule

// File: rtl/fault_vote_ctrl.sv
// Sequential N-way result voter: captures skewed channel results, votes bitwise,
// flags faults, keeps a saturating fault count and locks after MAXF faulty ops.
module fault_vote_ctrl
  import fault_vote_pkg::*;
#(
  parameter int unsigned N         = 3,
  parameter int unsigned W         = 128,
  parameter int unsigned TW        = 8,
  parameter int unsigned MAXF      = 4,
  parameter int unsigned MASK_MODE = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [N-1:0]                 ch_valid,
  input  logic [N*W-1:0]               ch_data,
  input  logic [W-1:0]                 random_mask,
  output logic                         out_valid,
  output logic [W-1:0]                 out_data,
  output logic                         fault,
  output logic [cnt_width(MAXF)-1:0]   fault_cnt,
  output logic                         locked
);

  localparam int unsigned CNT_W = cnt_width(MAXF);
  localparam int unsigned AW    = $clog2(N + 1);
  localparam int unsigned SW    = $clog2(TW + 1);

  state_e           state_q, state_d;
  logic [N-1:0]     cap_q, cap_d;
  logic [N*W-1:0]   regs_q, regs_d;
  logic [SW-1:0]    skew_q, skew_d;
  logic             timeout_q, timeout_d;
  logic [W-1:0]     out_data_q, out_data_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] fault_cnt_q, fault_cnt_d;

  logic [W-1:0]     maj;
  logic [AW-1:0]    agree;
  logic             mismatch;
  logic             accept;
  logic             fault_next;

  bit_majority_n #(
    .N (N),
    .W (W)
  ) u_majority (
    .regs_i  (regs_q),
    .cap_i   (cap_q),
    .maj_o   (maj),
    .agree_o (agree)
  );

  always_comb begin
    mismatch = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (cap_q[i] && (regs_q[i*W +: W] != maj)) mismatch = 1'b1;
    end
  end

  assign accept     = (agree >= AW'((N + 1) / 2));
  assign fault_next = timeout_q | mismatch | ~accept;

  always_comb begin
    state_d     = state_q;
    cap_d       = cap_q;
    regs_d      = regs_q;
    skew_d      = skew_q;
    timeout_d   = timeout_q;
    out_data_d  = out_data_q;
    fault_d     = fault_q;
    fault_cnt_d = fault_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StCollect;
          cap_d     = '0;
          regs_d    = '0;
          skew_d    = '0;
          timeout_d = 1'b0;
          fault_d   = 1'b0;
        end
      end
      StCollect: begin
        for (int i = 0; i < N; i++) begin
          if (ch_valid[i] && !cap_q[i]) regs_d[i*W +: W] = ch_data[i*W +: W];
        end
        cap_d = cap_q | ch_valid;
        if (cap_d != '0) skew_d = skew_q + SW'(1);
        // Full capture wins over timeout when both land in the same cycle.
        if (&cap_d) begin
          state_d = StVote;
        end else if (skew_q == SW'(TW)) begin
          state_d   = StVote;
          timeout_d = 1'b1;
        end
      end
      StVote: begin
        if (accept) out_data_d = maj;
        else        out_data_d = (MASK_MODE != 0) ? random_mask : '0;
        fault_d = fault_next;
        if (fault_next && (fault_cnt_q != CNT_W'(MAXF))) fault_cnt_d = fault_cnt_q + CNT_W'(1);
        state_d = StDone;
      end
      StDone: begin
        state_d = (fault_cnt_q == CNT_W'(MAXF)) ? StLock : StIdle;
      end
      StLock: begin
        state_d = StLock;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cap_q       <= '0;
      regs_q      <= '0;
      skew_q      <= '0;
      timeout_q   <= 1'b0;
      out_data_q  <= '0;
      fault_q     <= 1'b0;
      fault_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cap_q       <= cap_d;
      regs_q      <= regs_d;
      skew_q      <= skew_d;
      timeout_q   <= timeout_d;
      out_data_q  <= out_data_d;
      fault_q     <= fault_d;
      fault_cnt_q <= fault_cnt_d;
    end
  end

  assign out_valid = (state_q == StDone);
  assign locked    = (state_q == StLock);
  assign out_data  = locked ? '0 : out_data_q;
  assign fault     = fault_q;
  assign fault_cnt = fault_cnt_q;

endmodule

// File: tb/tb_fault_vote_ctrl.sv
// Randomized bench for fault_vote_ctrl with a per-operation reference model
// derived from arrival delays and channel values.
module tb_fault_vote_ctrl;

  localparam int N    = 3;
  localparam int W    = 8;
  localparam int TW   = 8;
  localparam int MAXF = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [N-1:0]   ch_valid;
  logic [N*W-1:0] ch_data;
  logic [W-1:0]   random_mask;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           fault;
  logic [2:0]     fault_cnt;
  logic           locked;

  fault_vote_ctrl #(
    .N         (N),
    .W         (W),
    .TW        (TW),
    .MAXF      (MAXF),
    .MASK_MODE (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .ch_valid    (ch_valid),
    .ch_data     (ch_data),
    .random_mask (random_mask),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .fault       (fault),
    .fault_cnt   (fault_cnt),
    .locked      (locked)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state and the current operation's stimulus.
  int         m_cnt;
  logic [7:0] op_data[N];
  int         op_dly[N];   // cycles after first capture; -1 = never valid
  int         op_pre;
  logic [7:0] last_data;
  logic       last_fault;
  logic       last_seen;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    start    = 1'b0;
    ch_valid = '0;
    tick();
    rst = 1'b0;
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_data", out_data, 0);
    check_val("rst_fault", fault, 0);
    check_val("rst_fault_cnt", fault_cnt, 0);
    check_val("rst_locked", locked, 0);
    m_cnt = 0;
  endtask

  // Called at a sampling point with the DUT idle (or locked).
  task automatic run_op();
    logic [N-1:0] capm;
    logic [7:0]   maj;
    logic [7:0]   exp_out;
    int           tmax;
    int           agree;
    int           ones;
    int           t_exp;
    bit           to;
    bit           mism;
    bit           acc;
    bit           f;
    bit           exp_v;
    bit           was_locked;
    was_locked = (m_cnt == MAXF);
    capm = '0;
    tmax = 0;
    to   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (op_dly[i] < 0 || op_dly[i] > TW) to = 1'b1;
      else begin
        capm[i] = 1'b1;
        if (op_dly[i] > tmax) tmax = op_dly[i];
      end
    end
    for (int b = 0; b < W; b++) begin
      ones = 0;
      for (int i = 0; i < N; i++) if (capm[i] && op_data[i][b]) ones++;
      maj[b] = (ones > N / 2);
    end
    agree = 0;
    mism  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (capm[i]) begin
        if (op_data[i] == maj) agree++;
        else mism = 1'b1;
      end
    end
    acc     = (agree >= (N + 1) / 2);
    f       = to || mism || !acc;
    exp_out = acc ? maj : random_mask;
    t_exp   = to ? TW + 2 : tmax + 2;
    last_seen = 1'b0;

    // ch_valid must be ignored while idle.
    start    = 1'b1;
    ch_valid = N'($urandom);
    ch_data  = N*W'($urandom);
    tick();
    start = 1'b0;
    if (!was_locked) check_val("start_clears_fault", fault, 0);
    for (int p = 0; p < op_pre; p++) begin
      ch_valid = '0;
      ch_data  = N*W'($urandom);
      tick();
    end
    for (int t = 0; t <= t_exp + 1; t++) begin
      exp_v = !was_locked && (t == t_exp);
      check_val("out_valid", out_valid, exp_v);
      if (out_valid) begin
        last_seen  = 1'b1;
        last_data  = out_data;
        last_fault = fault;
      end
      if (exp_v) begin
        check_val("out_data", out_data, exp_out);
        check_val("fault", fault, f);
        check_val("fault_cnt", fault_cnt, (m_cnt + f > MAXF) ? MAXF : m_cnt + f);
        check_val("locked_in_done", locked, 0);
      end
      for (int i = 0; i < N; i++) begin
        ch_valid[i] = (op_dly[i] >= 0) && (t >= op_dly[i]);
        // Data after capture is noise that must not be picked up.
        ch_data[i*W +: W] = (t == op_dly[i]) ? op_data[i] : 8'($urandom);
      end
      tick();
    end
    ch_valid = '0;
    if (was_locked) begin
      check_val("lock_out_data", out_data, 0);
      check_val("lock_stays", locked, 1);
    end else begin
      if (f && m_cnt < MAXF) m_cnt++;
      check_val("locked_after_done", locked, m_cnt == MAXF);
      check_val("fault_held", fault, f);
    end
  endtask

  task automatic set_op(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                        input int l0, input int l1, input int l2);
    op_data[0] = d0;
    op_data[1] = d1;
    op_data[2] = d2;
    op_dly[0]  = l0;
    op_dly[1]  = l1;
    op_dly[2]  = l2;
    op_pre     = 0;
  endtask

  task automatic rand_op();
    logic [7:0] base;
    int         r;
    int         mn;
    bit         any;
    base = 8'($urandom);
    any  = 1'b0;
    mn   = 100;
    for (int i = 0; i < N; i++) begin
      r = $urandom_range(0, 99);
      if (r < 65)      op_data[i] = base;
      else if (r < 85) op_data[i] = base ^ (8'd1 << $urandom_range(0, 7));
      else             op_data[i] = 8'($urandom);
      r = $urandom_range(0, 99);
      if (r < 70)      op_dly[i] = $urandom_range(0, 7);
      else if (r < 80) op_dly[i] = TW;
      else if (r < 90) op_dly[i] = $urandom_range(TW + 1, TW + 4);
      else             op_dly[i] = -1;
      if (op_dly[i] >= 0) begin
        any = 1'b1;
        if (op_dly[i] < mn) mn = op_dly[i];
      end
    end
    if (!any) begin
      op_dly[0] = 0;
      mn = 0;
    end
    for (int i = 0; i < N; i++) if (op_dly[i] >= 0) op_dly[i] -= mn;
    op_pre      = $urandom_range(0, 3);
    random_mask = 8'($urandom);
  endtask

  initial begin
    rst         = 1'b0;
    start       = 1'b0;
    ch_valid    = '0;
    ch_data     = '0;
    random_mask = 8'h3C;
    m_cnt       = 0;
    tick();
    do_reset();

    // All agree, all valid together.
    set_op(8'hA5, 8'hA5, 8'hA5, 0, 0, 0);
    run_op();
    check_val("t1_data", last_data, 8'hA5);
    check_val("t1_fault", last_fault, 0);
    // One dissenting channel.
    set_op(8'hA5, 8'hA5, 8'h5A, 0, 0, 0);
    run_op();
    check_val("t2_data", last_data, 8'hA5);
    check_val("t2_cnt", fault_cnt, 1);
    // No agreement: substitution value.
    set_op(8'h01, 8'h02, 8'h04, 0, 0, 0);
    run_op();
    check_val("t3_data", last_data, 8'h3C);
    check_val("t3_fault", last_fault, 1);
    // Timeout with one missing channel, then a staggered but in-window repeat.
    set_op(8'h77, 8'h77, 8'h77, 0, 0, -1);
    run_op();
    check_val("t4_data", last_data, 8'h77);
    check_val("t4_fault", last_fault, 1);
    set_op(8'h77, 8'h77, 8'h77, 0, 0, 3);
    run_op();
    check_val("t4b_fault", last_fault, 0);
    // Late arrival exactly at the window edge still counts.
    set_op(8'h3A, 8'h3A, 8'h3A, 0, 2, TW);
    run_op();
    check_val("edge_fault", last_fault, 0);

    // Four faulty ops lock the block; start is then ignored.
    do_reset();
    for (int k = 0; k < MAXF; k++) begin
      set_op(8'hA5, 8'hA5, 8'h5A, 0, 0, 0);
      run_op();
    end
    check_val("t5_cnt", fault_cnt, MAXF);
    check_val("t5_locked", locked, 1);
    set_op(8'h11, 8'h11, 8'h11, 0, 0, 0);
    run_op();
    check_val("t5_no_valid", last_seen, 0);
    do_reset();

    // Reset mid-collect abandons the op.
    start = 1'b1;
    tick();
    start    = 1'b0;
    ch_valid = 3'b001;
    ch_data  = 24'h0000C3;
    tick();
    ch_valid = '0;
    rst      = 1'b1;
    tick();
    rst = 1'b0;
    check_val("t6_out_valid", out_valid, 0);
    check_val("t6_out_data", out_data, 0);
    check_val("t6_fault", fault, 0);
    check_val("t6_locked", locked, 0);
    for (int k = 0; k < 4; k++) begin
      check_val("t6_quiet", out_valid, 0);
      tick();
    end
    set_op(8'h42, 8'h42, 8'h42, 0, 1, 0);
    run_op();
    check_val("t6_after", last_data, 8'h42);

    // Randomized operations, resetting whenever the model locks.
    for (int k = 0; k < 60; k++) begin
      if (m_cnt == MAXF) begin
        rand_op();
        run_op();
        do_reset();
      end
      rand_op();
      run_op();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
